scroll_sequencer: RTL and testbench

Message-scroll controller that sequences what the four-digit seven-segment driver displays. It holds a writable message buffer of up to 16 characters, slides a 4-character window across it at a prescaled step rate, pauses at the start of each pass, and presents the window as four hex nibbles plus per-digit blank flags. Its outputs feed the digit driver's value and blank inputs; the digit driver still owns anode multiplexing and segment decoding.

---
 rtl/scroll_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_scroll_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_sequencer.sv
// scroll_sequencer: holds a 16-entry message buffer and slides a 4-character
// window across it at a prescaled step rate. The window pauses at position 0
// for a fixed number of steps after each pass. All outputs are registered.
module scroll_sequencer #(
  parameter int TICK_DIV   = 12_500_000,
  parameter int HOLD_STEPS = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [4:0]  wr_data,
  input  logic [4:0]  msg_len,
  input  logic        start,
  input  logic        stop,
  output logic        busy,
  output logic [15:0] win_digits,
  output logic [3:0]  win_blank,
  output logic [3:0]  pos,
  output logic        step
);

  typedef enum logic [1:0] {IDLE, SCROLL, HOLD} state_t;

  localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);
  localparam logic [3:0]  HOLD_LAST = 4'(HOLD_STEPS);

  state_t      state_reg, state_next;
  logic [23:0] prescale_reg, prescale_next;
  logic [3:0]  pos_reg, pos_next;
  logic [4:0]  len_reg, len_next;
  logic [3:0]  hold_reg, hold_next;
  logic [15:0] digits_reg, digits_next;
  logic [3:0]  blank_reg, blank_next;
  logic        step_reg, step_next;

  logic [4:0]  msg_buf [16];

  logic        tick;
  logic [3:0]  pos_inc;
  logic [3:0]  hold_inc;
  logic [4:0]  len_clamp;
  logic [3:0]  load_pos;
  logic [4:0]  len_view;
  logic [15:0] win_digits_w;
  logic [3:0]  win_blank_w;

  // Reduce (base) into 0..len-1; base never exceeds 18 and len is at least 1,
  // so three conditional subtractions always suffice (worst case len = 1).
  function automatic logic [3:0] wrap_idx(input logic [4:0] base, input logic [4:0] len);
    logic [4:0] idx;
    idx = base;
    for (int k = 0; k < 3; k++) begin
      if (idx >= len) idx = idx - len;
    end
    return idx[3:0];
  endfunction

  assign tick      = (prescale_reg == TICK_LAST);
  assign pos_inc   = (({1'b0, pos_reg} + 5'd1) >= len_reg) ? 4'd0 : pos_reg + 4'd1;
  assign hold_inc  = hold_reg + 4'd1;
  assign len_clamp = (msg_len == 5'd0) ? 5'd1 : ((msg_len > 5'd16) ? 5'd16 : msg_len);

  // The window about to be loaded: position 0 with the fresh length on start,
  // the advanced position on a scroll tick, the current position while holding.
  assign load_pos = (state_reg == SCROLL) ? pos_inc :
                    ((state_reg == HOLD) ? pos_reg : 4'd0);
  assign len_view = (state_reg == IDLE) ? len_clamp : len_reg;

  genvar gi;

  // Message buffer: plain registers so every entry can reset to blank.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_buf
      always_ff @(posedge CLK) begin
        if (RESET)
          msg_buf[gi] <= 5'h10;
        else if (wr_en && (wr_addr == 4'(gi)))
          msg_buf[gi] <= wr_data;
      end
    end
  endgenerate

  // Window fetch: digit gi (0 = leftmost) shows buffer[(load_pos + gi) mod len].
  generate
    for (gi = 0; gi < 4; gi++) begin : g_win
      logic [4:0] entry;
      assign entry = msg_buf[wrap_idx({1'b0, load_pos} + 5'(gi), len_view)];
      assign win_digits_w[15 - 4*gi -: 4] = entry[3:0];
      assign win_blank_w[3 - gi]          = entry[4];
    end
  endgenerate

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic: stop dominates, start only matters from IDLE.
  always_comb begin
    state_next = state_reg;
    if (stop) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (start) state_next = SCROLL;
        SCROLL:  if (tick && (pos_inc == 4'd0)) state_next = HOLD;
        HOLD:    if (tick && (hold_inc == HOLD_LAST)) state_next = SCROLL;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output/datapath next values: prescaler, position, hold count and window.
  always_comb begin
    prescale_next = prescale_reg;
    pos_next      = pos_reg;
    len_next      = len_reg;
    hold_next     = hold_reg;
    digits_next   = digits_reg;
    blank_next    = blank_reg;
    step_next     = 1'b0;
    if (stop) begin
      prescale_next = '0;
      pos_next      = 4'd0;
      hold_next     = 4'd0;
      digits_next   = 16'h0000;
      blank_next    = 4'hF;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            len_next      = len_clamp;
            prescale_next = '0;
            pos_next      = 4'd0;
            hold_next     = 4'd0;
            digits_next   = win_digits_w;
            blank_next    = win_blank_w;
            step_next     = 1'b1;
          end
        end
        SCROLL: begin
          prescale_next = tick ? '0 : prescale_reg + 24'd1;
          if (tick) begin
            pos_next    = pos_inc;
            hold_next   = 4'd0;
            digits_next = win_digits_w;
            blank_next  = win_blank_w;
            step_next   = 1'b1;
          end
        end
        HOLD: begin
          prescale_next = tick ? '0 : prescale_reg + 24'd1;
          if (tick) begin
            hold_next   = hold_inc;
            digits_next = win_digits_w;
            blank_next  = win_blank_w;
            step_next   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prescale_reg <= '0;
      pos_reg      <= 4'd0;
      len_reg      <= 5'd1;
      hold_reg     <= 4'd0;
      digits_reg   <= 16'h0000;
      blank_reg    <= 4'hF;
      step_reg     <= 1'b0;
    end else begin
      prescale_reg <= prescale_next;
      pos_reg      <= pos_next;
      len_reg      <= len_next;
      hold_reg     <= hold_next;
      digits_reg   <= digits_next;
      blank_reg    <= blank_next;
      step_reg     <= step_next;
    end
  end

  assign busy       = (state_reg != IDLE);
  assign win_digits = digits_reg;
  assign win_blank  = blank_reg;
  assign pos        = pos_reg;
  assign step       = step_reg;

endmodule

// File: tb/tb_scroll_sequencer.sv
// Bench for scroll_sequencer: directed stimulus pushes the expected window
// for every step pulse into a queue; a monitor pops and compares on each step.
module tb_scroll_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [4:0]  wr_data;
  logic [4:0]  msg_len;
  logic        start;
  logic        stop;
  logic        busy;
  logic [15:0] win_digits;
  logic [3:0]  win_blank;
  logic [3:0]  pos;
  logic        step;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_step = 0;

  typedef struct {
    logic [3:0]  pos;
    logic [15:0] digits;
    logic [3:0]  blank;
    int          gap;   // cycles since previous step, 0 = not checked
  } exp_t;

  exp_t sb[$];

  scroll_sequencer #(.TICK_DIV(4), .HOLD_STEPS(2)) dut (
    .CLK(clk),
    .RESET(rst),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .msg_len(msg_len),
    .start(start),
    .stop(stop),
    .busy(busy),
    .win_digits(win_digits),
    .win_blank(win_blank),
    .pos(pos),
    .step(step)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every step pulse must match the next queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (step) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_step got pos=%0d digits=%h blank=%h required no step",
                 pos, win_digits, win_blank);
      end else begin
        e = sb.pop_front();
        if (pos !== e.pos || win_digits !== e.digits || win_blank !== e.blank) begin
          errors++;
          $display("FAIL step_window got pos=%0d digits=%h blank=%h required pos=%0d digits=%h blank=%h",
                   pos, win_digits, win_blank, e.pos, e.digits, e.blank);
        end else begin
          $display("step pos=%0d digits=%h blank=%h cycle=%0d", pos, win_digits, win_blank, cyc);
        end
        if (e.gap != 0) begin
          checks++;
          if (cyc - last_step != e.gap) begin
            errors++;
            $display("FAIL step_gap got %0d required %0d", cyc - last_step, e.gap);
          end
        end
      end
      last_step = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end else begin
      $display("check %s = %h", name, got);
    end
  endtask

  task automatic push(input logic [3:0] p, input logic [15:0] d, input logic [3:0] b, input int g);
    exp_t e;
    e.pos = p; e.digits = d; e.blank = b; e.gap = g;
    sb.push_back(e);
  endtask

  task automatic write_buf(input logic [3:0] a, input logic [4:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [4:0] len);
    msg_len = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},   32'(busy), 32'd0);
    check({tag, "_blank"},  32'(win_blank), 32'hF);
    check({tag, "_digits"}, 32'(win_digits), 32'h0);
    check({tag, "_pos"},    32'(pos), 32'd0);
  endtask

  // Wait (bounded) until the monitor has consumed every expected step.
  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending steps required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 5'd0;
    msg_len = 5'd0; start = 1'b0; stop = 1'b0;
    tick(); tick();
    check_idle_outputs("reset");
    check("reset_step", 32'(step), 32'd0);
    rst = 1'b0;
    tick();

    // Basic scroll over "123456" with wrap and two hold steps.
    for (int i = 0; i < 6; i++) write_buf(4'(i), 5'(i + 1));
    push(4'd0, 16'h1234, 4'h0, 0);
    push(4'd1, 16'h2345, 4'h0, 4);
    push(4'd2, 16'h3456, 4'h0, 4);
    push(4'd3, 16'h4561, 4'h0, 4);
    push(4'd4, 16'h5612, 4'h0, 4);
    push(4'd5, 16'h6123, 4'h0, 4);
    push(4'd0, 16'h1234, 4'h0, 4);
    push(4'd0, 16'h1234, 4'h0, 4);
    push(4'd0, 16'h1234, 4'h0, 4);
    push(4'd1, 16'h2345, 4'h0, 4);
    pulse_start(5'd6);
    check("start_busy", 32'(busy), 32'd1);
    drain(80);
    do_stop();
    check_idle_outputs("stop_basic");

    // Reset mid-scroll clears state and the whole buffer.
    push(4'd0, 16'h1234, 4'h0, 0);
    pulse_start(5'd6);
    rst = 1'b1;
    tick(); tick();
    check_idle_outputs("reset_scroll");
    rst = 1'b0;
    tick();
    push(4'd0, 16'h0000, 4'hF, 0);
    push(4'd1, 16'h0000, 4'hF, 4);
    pulse_start(5'd16);
    drain(20);
    do_stop();

    // msg_len = 20 clamps to 16 and wraps after index 15.
    for (int i = 0; i < 16; i++) write_buf(4'(i), 5'(i));
    for (int p = 0; p < 16; p++) begin
      logic [15:0] d;
      d = {4'(p), 4'((p + 1) % 16), 4'((p + 2) % 16), 4'((p + 3) % 16)};
      push(4'(p), d, 4'h0, (p == 0) ? 0 : 4);
    end
    push(4'd0, 16'h0123, 4'h0, 4);
    pulse_start(5'd20);
    drain(120);
    do_stop();

    // Start and stop together from IDLE: no start.
    msg_len = 5'd6; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check_idle_outputs("start_stop");
    repeat (6) tick();
    check("start_stop_later_busy", 32'(busy), 32'd0);

    // Start while busy does not restart the sequence.
    push(4'd0, 16'h0123, 4'h0, 0);
    push(4'd1, 16'h1234, 4'h0, 4);
    push(4'd2, 16'h2345, 4'h0, 4);
    push(4'd3, 16'h3450, 4'h0, 4);
    pulse_start(5'd6);
    repeat (5) tick();
    pulse_start(5'd6);
    drain(40);
    do_stop();

    // Write to buffer[2] on the edge that loads pos 1: old value shown first.
    push(4'd0, 16'h0123, 4'h0, 0);
    push(4'd1, 16'h1234, 4'h0, 4);
    push(4'd2, 16'hF345, 4'h0, 4);
    push(4'd3, 16'h3450, 4'h0, 4);
    pulse_start(5'd6);
    repeat (3) tick();
    write_buf(4'd2, 5'h0F);
    drain(40);
    do_stop();

    // Stop while hold_cnt = 1, then restart with a fresh prescaler.
    push(4'd0, 16'h0101, 4'h0, 0);
    push(4'd1, 16'h1010, 4'h0, 4);
    push(4'd0, 16'h0101, 4'h0, 4);
    push(4'd0, 16'h0101, 4'h0, 4);
    pulse_start(5'd2);
    drain(40);
    do_stop();
    check_idle_outputs("stop_hold");
    check("stop_hold_step", 32'(step), 32'd0);
    tick();
    push(4'd0, 16'h0101, 4'h0, 0);
    push(4'd1, 16'h1010, 4'h0, 4);
    push(4'd0, 16'h0101, 4'h0, 4);
    pulse_start(5'd2);
    drain(40);
    do_stop();

    // msg_len = 0 clamps to 1: every step shows AAAA at pos 0.
    write_buf(4'd0, 5'h0A);
    push(4'd0, 16'hAAAA, 4'h0, 0);
    for (int i = 0; i < 5; i++) push(4'd0, 16'hAAAA, 4'h0, 4);
    pulse_start(5'd0);
    drain(60);
    do_stop();
    check_idle_outputs("stop_len1");

    repeat (6) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
